// File: rtl/cpu_pkg.sv
// Shared core constants and register/word typedefs used by the writeback arbiter.
package cpu_pkg;
    localparam int DW         = 32;
    localparam int AW         = 5;
    localparam int NUM_REGS   = 2 ** AW;
    localparam int STARVE_MAX = 4;

    typedef logic [AW-1:0] reg_addr_t;
    typedef logic [DW-1:0] word_t;
endpackage

// File: rtl/md_result_buf.sv
// One-entry holding register for mul/div results awaiting a register file write slot.
module md_result_buf #(
    parameter int DW = cpu_pkg::DW,
    parameter int AW = cpu_pkg::AW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [AW-1:0] in_addr,
    input  logic [DW-1:0] in_data,
    input  logic          drain,
    output logic          buf_valid,
    output logic [AW-1:0] buf_addr,
    output logic [DW-1:0] buf_data
);
    // Handshake: a result transfers on a rising edge where in_valid && in_ready.
    // The producer keeps in_addr/in_data stable while in_valid is high and
    // in_ready is low. in_ready never depends on in_valid, and a draining entry
    // frees the slot in the same cycle so results can stream one per cycle.
    logic accept;

    assign in_ready = !buf_valid || drain;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_valid <= 1'b0;
            buf_addr  <= '0;
            buf_data  <= '0;
        end else if (accept) begin
            buf_valid <= 1'b1;
            buf_addr  <= in_addr;
            buf_data  <= in_data;
        end else if (drain) begin
            buf_valid <= 1'b0;
        end
    end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file write port between the WB stage and the mul/div unit,
// with a starvation-bounded result buffer and a pending-destination scoreboard.
module regfile_wb_arbiter #(
    parameter int DW         = cpu_pkg::DW,
    parameter int AW         = cpu_pkg::AW,
    parameter int STARVE_MAX = cpu_pkg::STARVE_MAX
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          pipe_we,
    input  logic [AW-1:0] pipe_waddr,
    input  logic [DW-1:0] pipe_wdata,
    input  logic          md_valid,
    output logic          md_ready,
    input  logic [AW-1:0] md_waddr,
    input  logic [DW-1:0] md_wdata,
    input  logic          md_issue,
    input  logic [AW-1:0] md_issue_rd,
    input  logic [AW-1:0] dec_rs,
    input  logic [AW-1:0] dec_rt,
    input  logic          dec_uses_rs,
    input  logic          dec_uses_rt,
    input  logic [AW-1:0] dec_rd,
    input  logic          dec_writes,
    output logic          dec_stall,
    output logic          pipe_hold,
    output logic          rf_we,
    output logic [AW-1:0] rf_waddr,
    output logic [DW-1:0] rf_wdata
);
    localparam int NUM_REGS = 2 ** AW;
    localparam int CW       = $clog2(STARVE_MAX + 1);

    logic                buf_valid;
    logic [AW-1:0]       buf_addr;
    logic [DW-1:0]       buf_data;
    logic                pipe_req;
    logic                force_drain;
    logic                drain;
    logic [CW-1:0]       cnt;
    logic [NUM_REGS-1:0] pending;
    logic [NUM_REGS-1:0] pending_nxt;

    md_result_buf #(.DW(DW), .AW(AW)) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (md_valid),
        .in_ready  (md_ready),
        .in_addr   (md_waddr),
        .in_data   (md_wdata),
        .drain     (drain),
        .buf_valid (buf_valid),
        .buf_addr  (buf_addr),
        .buf_data  (buf_data)
    );

    assign pipe_req    = pipe_we && (pipe_waddr != '0);
    assign force_drain = buf_valid && (cnt == CW'(STARVE_MAX));
    assign drain       = buf_valid && (!pipe_req || force_drain);
    assign pipe_hold   = force_drain && pipe_req;

    // A drained r0 result still frees the buffer but never writes the file.
    always_comb begin
        rf_we    = pipe_req;
        rf_waddr = pipe_waddr;
        rf_wdata = pipe_wdata;
        if (drain) begin
            rf_we    = (buf_addr != '0);
            rf_waddr = buf_addr;
            rf_wdata = buf_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!buf_valid || drain) begin
            cnt <= '0;
        end else if (cnt != CW'(STARVE_MAX)) begin
            cnt <= cnt + CW'(1);
        end
    end

    // Issue is applied after the drain clear so a re-issued destination stays pending.
    always_comb begin
        pending_nxt = pending;
        if (drain) begin
            pending_nxt[buf_addr] = 1'b0;
        end
        if (md_issue && (md_issue_rd != '0)) begin
            pending_nxt[md_issue_rd] = 1'b1;
        end
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
        end else begin
            pending <= pending_nxt;
        end
    end

    assign dec_stall = (dec_uses_rs && pending[dec_rs])
                    || (dec_uses_rt && pending[dec_rt])
                    || (dec_writes  && pending[dec_rd]);
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: reset, mul/div latency, starvation hold,
// back-pressure, scoreboard set-over-clear, r0 handling and asynchronous reset.
module tb_regfile_wb_arbiter;
    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk;
    logic          rst_n;
    logic          pipe_we;
    logic [AW-1:0] pipe_waddr;
    logic [DW-1:0] pipe_wdata;
    logic          md_valid;
    logic          md_ready;
    logic [AW-1:0] md_waddr;
    logic [DW-1:0] md_wdata;
    logic          md_issue;
    logic [AW-1:0] md_issue_rd;
    logic [AW-1:0] dec_rs;
    logic [AW-1:0] dec_rt;
    logic          dec_uses_rs;
    logic          dec_uses_rt;
    logic [AW-1:0] dec_rd;
    logic          dec_writes;
    logic          dec_stall;
    logic          pipe_hold;
    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;

    int checks = 0;
    int errors = 0;

    regfile_wb_arbiter #(.DW(DW), .AW(AW), .STARVE_MAX(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pipe_we     (pipe_we),
        .pipe_waddr  (pipe_waddr),
        .pipe_wdata  (pipe_wdata),
        .md_valid    (md_valid),
        .md_ready    (md_ready),
        .md_waddr    (md_waddr),
        .md_wdata    (md_wdata),
        .md_issue    (md_issue),
        .md_issue_rd (md_issue_rd),
        .dec_rs      (dec_rs),
        .dec_rt      (dec_rt),
        .dec_uses_rs (dec_uses_rs),
        .dec_uses_rt (dec_uses_rt),
        .dec_rd      (dec_rd),
        .dec_writes  (dec_writes),
        .dec_stall   (dec_stall),
        .pipe_hold   (pipe_hold),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver tasks: inputs change 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        pipe_we = 0; pipe_waddr = '0; pipe_wdata = '0;
        md_valid = 0; md_waddr = '0; md_wdata = '0;
        md_issue = 0; md_issue_rd = '0;
        dec_rs = '0; dec_rt = '0; dec_uses_rs = 0; dec_uses_rt = 0;
        dec_rd = '0; dec_writes = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 0;
        repeat (2) tick();
        rst_n = 1;
        tick();
        checks++; if (md_ready !== 1'b1) begin errors++; $display("FAIL reset_md_ready got %0b exp 1", md_ready); end
        checks++; if (dec_stall !== 1'b0) begin errors++; $display("FAIL reset_dec_stall got %0b exp 0", dec_stall); end
        checks++; if (pipe_hold !== 1'b0) begin errors++; $display("FAIL reset_pipe_hold got %0b exp 0", pipe_hold); end
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL reset_rf_we got %0b exp 0", rf_we); end
        pipe_we = 1; pipe_waddr = 5'd3; pipe_wdata = 32'hA5;
        #1;
        checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd3 || rf_wdata !== 32'hA5) begin
            errors++; $display("FAIL pipe_passthru got we=%0b a=%0d d=%h exp we=1 a=3 d=a5", rf_we, rf_waddr, rf_wdata);
        end
        tick();
        idle_inputs();
        #1;
    endtask

    task automatic test_md_latency();
        md_issue = 1; md_issue_rd = 5'd7;
        tick();
        md_issue = 0;
        dec_rs = 5'd7; dec_uses_rs = 1;
        #1;
        checks++; if (dec_stall !== 1'b1) begin errors++; $display("FAIL raw_stall got %0b exp 1", dec_stall); end
        dec_uses_rs = 0; dec_rd = 5'd7; dec_writes = 1;
        #1;
        checks++; if (dec_stall !== 1'b1) begin errors++; $display("FAIL waw_stall got %0b exp 1", dec_stall); end
        dec_writes = 0; dec_uses_rs = 1;
        md_valid = 1; md_waddr = 5'd7; md_wdata = 32'h1234;
        #1;
        checks++; if (md_ready !== 1'b1 || rf_we !== 1'b0) begin
            errors++; $display("FAIL md_accept_cycle got ready=%0b we=%0b exp ready=1 we=0", md_ready, rf_we);
        end
        tick();
        md_valid = 0;
        #1;
        checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 32'h1234) begin
            errors++; $display("FAIL md_write got we=%0b a=%0d d=%h exp we=1 a=7 d=1234", rf_we, rf_waddr, rf_wdata);
        end
        checks++; if (dec_stall !== 1'b1) begin errors++; $display("FAIL stall_before_clear got %0b exp 1", dec_stall); end
        tick();
        checks++; if (dec_stall !== 1'b0) begin errors++; $display("FAIL stall_after_clear got %0b exp 0", dec_stall); end
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL md_single_write got %0b exp 0", rf_we); end
        idle_inputs();
        #1;
    endtask

    // Continuous WB writes: first result (r4) starves 4 cycles then forces a hold;
    // a second result (r6) waits behind it and is accepted on the forced drain edge.
    task automatic test_starve_and_backpressure();
        pipe_we = 1; pipe_waddr = 5'd2; pipe_wdata = 32'h11;
        md_valid = 1; md_waddr = 5'd4; md_wdata = 32'hBEEF;
        tick();
        md_valid = 0;
        for (int i = 0; i < 4; i++) begin
            if (i >= 1) begin
                md_valid = 1; md_waddr = 5'd6; md_wdata = 32'h66;
            end
            #1;
            checks++; if (pipe_hold !== 1'b0 || rf_we !== 1'b1 || rf_waddr !== 5'd2 || rf_wdata !== 32'h11) begin
                errors++; $display("FAIL starve_blocked_%0d got hold=%0b we=%0b a=%0d d=%h exp hold=0 we=1 a=2 d=11", i, pipe_hold, rf_we, rf_waddr, rf_wdata);
            end
            checks++; if (md_ready !== 1'b0) begin errors++; $display("FAIL full_ready_%0d got %0b exp 0", i, md_ready); end
            tick();
        end
        #1;
        checks++; if (pipe_hold !== 1'b1 || rf_we !== 1'b1 || rf_waddr !== 5'd4 || rf_wdata !== 32'hBEEF) begin
            errors++; $display("FAIL force_drain got hold=%0b we=%0b a=%0d d=%h exp hold=1 we=1 a=4 d=beef", pipe_hold, rf_we, rf_waddr, rf_wdata);
        end
        checks++; if (md_ready !== 1'b1) begin errors++; $display("FAIL drain_ready got %0b exp 1", md_ready); end
        tick();
        md_valid = 0;
        // r6 now buffered with a fresh counter: 4 blocked cycles, then a hold
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (pipe_hold !== 1'b0 || rf_waddr !== 5'd2 || rf_wdata !== 32'h11) begin
                errors++; $display("FAIL held_wb_%0d got hold=%0b a=%0d d=%h exp hold=0 a=2 d=11", i, pipe_hold, rf_waddr, rf_wdata);
            end
            tick();
        end
        #1;
        checks++; if (pipe_hold !== 1'b1 || rf_waddr !== 5'd6 || rf_wdata !== 32'h66) begin
            errors++; $display("FAIL second_force got hold=%0b a=%0d d=%h exp hold=1 a=6 d=66", pipe_hold, rf_waddr, rf_wdata);
        end
        tick();
        idle_inputs();
        #1;
        checks++; if (md_ready !== 1'b1 || pipe_hold !== 1'b0) begin
            errors++; $display("FAIL buf_empty_after got ready=%0b hold=%0b exp ready=1 hold=0", md_ready, pipe_hold);
        end
    endtask

    task automatic test_set_wins_and_r0();
        md_issue = 1; md_issue_rd = 5'd5;
        tick();
        md_issue = 0;
        pipe_we = 1; pipe_waddr = 5'd9; pipe_wdata = 32'h1;
        md_valid = 1; md_waddr = 5'd5; md_wdata = 32'h55;
        tick();
        md_valid = 0; pipe_we = 0;
        md_issue = 1; md_issue_rd = 5'd5;
        #1;
        checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'h55) begin
            errors++; $display("FAIL drain_r5 got we=%0b a=%0d d=%h exp we=1 a=5 d=55", rf_we, rf_waddr, rf_wdata);
        end
        tick();
        md_issue = 0;
        dec_rt = 5'd5; dec_uses_rt = 1;
        #1;
        checks++; if (dec_stall !== 1'b1) begin errors++; $display("FAIL set_wins got %0b exp 1", dec_stall); end
        md_valid = 1; md_waddr = 5'd5; md_wdata = 32'h56;
        tick();
        md_valid = 0;
        tick();
        checks++; if (dec_stall !== 1'b0) begin errors++; $display("FAIL r5_cleared got %0b exp 0", dec_stall); end
        idle_inputs();
        pipe_we = 1; pipe_waddr = 5'd0; pipe_wdata = 32'hFF;
        #1;
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL pipe_r0 got %0b exp 0", rf_we); end
        pipe_we = 0;
        md_valid = 1; md_waddr = 5'd0; md_wdata = 32'hDEAD;
        #1;
        checks++; if (md_ready !== 1'b1) begin errors++; $display("FAIL md_r0_ready got %0b exp 1", md_ready); end
        tick();
        md_valid = 0;
        #1;
        checks++; if (rf_we !== 1'b0 || md_ready !== 1'b1) begin
            errors++; $display("FAIL md_r0_drop got we=%0b ready=%0b exp we=0 ready=1", rf_we, md_ready);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_async_reset();
        md_issue = 1; md_issue_rd = 5'd9;
        tick();
        md_issue = 0;
        pipe_we = 1; pipe_waddr = 5'd1; pipe_wdata = 32'h7;
        md_valid = 1; md_waddr = 5'd9; md_wdata = 32'h99;
        tick();
        md_valid = 0;
        dec_rs = 5'd9; dec_uses_rs = 1;
        #1;
        checks++; if (md_ready !== 1'b0 || dec_stall !== 1'b1) begin
            errors++; $display("FAIL pre_reset got ready=%0b stall=%0b exp ready=0 stall=1", md_ready, dec_stall);
        end
        #1;
        rst_n = 0;
        #1;
        checks++; if (md_ready !== 1'b1 || dec_stall !== 1'b0) begin
            errors++; $display("FAIL async_reset got ready=%0b stall=%0b exp ready=1 stall=0", md_ready, dec_stall);
        end
        pipe_we = 0;
        #1;
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL reset_no_write got %0b exp 0", rf_we); end
        tick();
        rst_n = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (rf_we !== 1'b0 || pipe_hold !== 1'b0 || dec_stall !== 1'b0) begin
                errors++; $display("FAIL post_reset_%0d got we=%0b hold=%0b stall=%0b exp all 0", i, rf_we, pipe_hold, dec_stall);
            end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_md_latency();
        test_starve_and_backpressure();
        test_set_wins_and_r0();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Shares the register file's single write port between the in-order pipeline writeback stage and a multi-cycle mul/div unit. Results from the mul/div unit are held in a one-entry buffer until a free write slot appears, or until a starvation limit forces a one-cycle pipeline hold. A per-register pending scoreboard marks mul/div destinations as in flight and stalls decode on RAW and WAW hazards against them. Sits between the WB stage, the mul/div unit, decode and the register file write port.

## Interface
- DW, 32: data width
- AW, 5: register address width (2**AW registers)
- STARVE_MAX, 4: consecutive cycles a buffered mul/div result may be blocked before the pipeline is held (≥1)

- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- pipe_we  in  1  WB stage write request
- pipe_waddr  in  AW  WB destination
- pipe_wdata  in  DW  WB data
- md_valid  in  1  mul/div result valid
- md_ready  out  1  buffer can accept result
- md_waddr  in  AW  mul/div destination
- md_wdata  in  DW  mul/div result
- md_issue  in  1  decode launches a mul/div op this cycle
- md_issue_rd  in  AW  destination of launched op
- dec_rs, dec_rt  in  AW  decode source registers
- dec_uses_rs, dec_uses_rt  in  1  source actually read
- dec_rd  in  AW  decode destination (any writing instr)
- dec_writes  in  1  decode instr writes dec_rd
- dec_stall  out  1  hazard on pending register
- pipe_hold  out  1  freeze pipeline, WB write deferred
- rf_we  out  1  register file write enable
- rf_waddr  out  AW  register file write address
- rf_wdata  out  DW  register file write data

## Operation
- Pipeline request pipe_req = pipe_we && pipe_waddr != 0. Mul/div writes to r0 are accepted and dropped (no rf write).
- Buffer: buf_valid, buf_addr, buf_data. Accept when md_valid && md_ready; md_ready = !buf_valid || drain.
- Grant, combinational from state and inputs:
  - force = buf_valid && cnt == STARVE_MAX.
  - drain = buf_valid && (!pipe_req || force).
  - If drain: rf_we=(buf_addr!=0), rf_waddr=buf_addr, rf_wdata=buf_data. Otherwise rf mirrors the pipeline: rf_we=pipe_req, rf_waddr=pipe_waddr, rf_wdata=pipe_wdata.
- pipe_hold = force && pipe_req. The WB stage keeps pipe_* stable and retries the next cycle.
- Starvation counter cnt (0..STARVE_MAX):
  - Cleared on drain or when !buf_valid.
  - Incremented while buf_valid && !drain.
  - Saturates.
- Scoreboard pending[2**AW], pending[0] is always 0:
  - Set on md_issue && md_issue_rd != 0.
  - Cleared on drain of buf_addr.
  - Set wins over clear on the same register in the same cycle.
- dec_stall = (dec_uses_rs && pending[dec_rs]) || (dec_uses_rt && pending[dec_rt]) || (dec_writes && pending[dec_rd]). Uses registered pending only.
- md_issue is asserted by decode only when dec_stall is low. No check inside.

## Timing
- Reset: buf_valid=0, cnt=0, pending=0. Hence md_ready=1, pipe_hold=0, dec_stall=0, rf_we=pipe_req (0 with idle inputs).
- Pipeline write latency 0: the write reaches the register file at the next edge, unchanged from a direct connection.
- Mul/div latency:
  - Accept at edge N.
  - Earliest rf write at edge N+1.
  - pending cleared at N+1, so dec_stall drops in cycle after N+1.
- Back-to-back mul/div results sustain one per cycle when the pipeline is idle (drain and accept in the same cycle).
- With continuous pipeline writes, a buffered result drains at most STARVE_MAX+1 cycles after acceptance: a hold cycle, then the WB write.
- Reset mid-operation drops the buffered result and clears all pending bits. The mul/div unit and pipeline are reset together.

## Structure
- Shared package cpu_pkg: DW, AW, NUM_REGS, STARVE_MAX default, reg_addr_t / word_t typedefs.
- One sub-module, md_result_buf: 1-entry valid/ready holding register with a drain input. Scoreboard, counter and grant stay in the top.

## Test plan
- Reset, idle inputs -> md_ready=1, dec_stall=0, pipe_hold=0, rf_we=0. pipe_we=1, addr 3, data 0xA5 -> rf_we=1, rf_waddr=3, same cycle.
- md_issue rd=7; decode dec_rs=7 -> dec_stall=1. md result 0x1234 to r7 with pipeline idle -> rf write r7=0x1234 one edge after accept. dec_stall=0 the following cycle.
- pipe_we=1 every cycle, STARVE_MAX=4, md result buffered -> blocked 4 cycles, then pipe_hold=1 with rf write of the mul/div result. Next cycle: held WB write, cnt=0.
- Second md_valid while buffer full and blocked -> md_ready=0, result unchanged until drain. Drain and new accept occur on the same edge.
- Simultaneous md_issue rd=5 and drain of old r5 -> pending[5]=1 after the edge (set wins). pipe_we to r0 -> rf_we=0. md result to r0 -> accepted, no rf write.
- rst_n low while buffer full and pending[9]=1 -> asynchronously buf_valid=0, pending cleared, no rf write after release.
